muldiv_controller: RTL and testbench



---
 rtl/muldiv_controller_pkg.sv | 30 +++
 rtl/muldiv_controller_if.sv | 28 ++
 rtl/muldiv_controller_md_iter_core.sv | 50 +++++
 rtl/muldiv_controller.sv | 166 ++++++++++++++++
 tb/tb_muldiv_controller.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_controller_pkg.sv
// Shared decode constants and FSM encodings for the RV32M multiply/divide controller.
// Pure definitions: no latency or backpressure of its own.
package muldiv_controller_pkg;

    localparam logic [3:0] INST_R_TYPE  = 4'd1;
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;
    localparam logic [1:0] MD_DONE = 2'd3;

    function automatic logic src1_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    function automatic logic src2_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_controller_if.sv
// EX-stage request/response bundle between the pipeline (master) and the muldiv controller (slave).
// No flow control beyond stall: the master holds the instruction while stall is high.
interface muldiv_controller_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [3:0]      instType;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            isMulDiv;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall;

    modport master (
        output start, flush, instType, func3, func7, src1, src2,
        input  isMulDiv, busy, done, result, stall
    );

    modport slave (
        input  start, flush, instType, func3, func7, src1, src2,
        output isMulDiv, busy, done, result, stall
    );
endinterface

// File: rtl/muldiv_controller_md_iter_core.sv
// Iterative unsigned datapath: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// After XLEN steps the product is {hi,lo}; for divides the quotient is in lo and the remainder in hi.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [XLEN-1:0] m;
    logic            div_mode;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;

    // rem_shift < 2*m always holds, so the XLEN+1-bit difference never wraps its sign bit.
    always_comb begin
        add_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        rem_shift = {hi, lo[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, m};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            hi       <= '0;
            lo       <= op_a;
            m        <= op_b;
            div_mode <= is_div;
        end else if (step) begin
            if (div_mode) begin
                hi <= rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~rem_diff[XLEN]};
            end else begin
                {hi, lo} <= {add_sum, lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// RV32M multiply/divide controller: decode, sign handling, special cases and FSM around md_iter_core; done at accept+XLEN+2 (special cases accept+1).
// Stalls EX from accept until done; optional MULDIV_FAST_MUL_EN makes multiplies single-cycle while divides stay iterative.
module muldiv_controller
    import muldiv_controller_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_controller_if.slave  bus
);
    localparam int              CNT_W   = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       op;
    logic             neg1;
    logic             neg2;
    logic [XLEN-1:0]  result_q;

    logic             md;
    logic             accept;
    logic             busy;
    logic             is_div;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic [XLEN-1:0]  special_val;
    logic [XLEN-1:0]  core_hi;
    logic [XLEN-1:0]  core_lo;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  fix_val;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod;

    assign md     = (bus.instType == INST_R_TYPE) && (bus.func7 == FUNC7_MULDIV);
    assign accept = (state == MD_IDLE) && bus.start && md && !bus.flush;
    assign busy   = (state == MD_CALC) || (state == MD_FIX);

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending to 2*XLEN and keeping only 2*XLEN product bits is exact for every signedness mix.
    logic [2*XLEN-1:0] fast_a;
    logic [2*XLEN-1:0] fast_b;
    logic [2*XLEN-1:0] fast_p;
    logic [XLEN-1:0]   fast_val;

    always_comb begin
        fast_a   = {{XLEN{src1_signed(bus.func3) & bus.src1[XLEN-1]}}, bus.src1};
        fast_b   = {{XLEN{src2_signed(bus.func3) & bus.src2[XLEN-1]}}, bus.src2};
        fast_p   = fast_a * fast_b;
        fast_val = (bus.func3 == MD_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        is_div   = bus.func3[2];
        a_neg    = src1_signed(bus.func3) && bus.src1[XLEN-1];
        b_neg    = src2_signed(bus.func3) && bus.src2[XLEN-1];
        mag_a    = a_neg ? -bus.src1 : bus.src1;
        mag_b    = b_neg ? -bus.src2 : bus.src2;
        div_zero = is_div && (bus.src2 == '0);
        div_ovf  = ((bus.func3 == MD_DIV) || (bus.func3 == MD_REM)) &&
                   (bus.src1 == MIN_INT) && (bus.src2 == '1);
        special  = div_zero || div_ovf;
        special_val = '0;
        // func3[1] separates the remainder ops from the quotient ops.
        if (div_zero) begin
            special_val = bus.func3[1] ? bus.src1 : '1;
        end else if (div_ovf) begin
            special_val = bus.func3[1] ? '0 : MIN_INT;
        end
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) begin
            special     = 1'b1;
            special_val = fast_val;
        end
`endif
    end

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && !special),
        .step   ((state == MD_CALC) && !bus.flush),
        .is_div (is_div),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .hi     (core_hi),
        .lo     (core_lo)
    );

    // Magnitudes went through the core, so the operand signs are reapplied here.
    assign prod_mag = {core_hi, core_lo};
    assign prod     = (neg1 ^ neg2) ? -prod_mag : prod_mag;
    assign quo      = (neg1 ^ neg2) ? -core_lo : core_lo;
    assign rem      = neg1 ? -core_hi : core_hi;

    always_comb begin
        fix_val = rem;
        case (op)
            MD_MUL:                       fix_val = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_val = quo;
            default:                      fix_val = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MD_IDLE;
            counter  <= '0;
            op       <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        op   <= bus.func3;
                        neg1 <= a_neg;
                        neg2 <= b_neg;
                        if (special) begin
                            result_q <= special_val;
                            state    <= MD_DONE;
                        end else begin
                            counter <= CNT_W'(XLEN - 1);
                            state   <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (bus.flush) begin
                        state <= MD_IDLE;
                    end else if (counter == '0) begin
                        state <= MD_FIX;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                MD_FIX: begin
                    if (bus.flush) begin
                        state <= MD_IDLE;
                    end else begin
                        result_q <= fix_val;
                        state    <= MD_DONE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign bus.isMulDiv = md;
    assign bus.busy     = busy;
    assign bus.done     = (state == MD_DONE);
    assign bus.result   = result_q;
    assign bus.stall    = (bus.start && md && (state == MD_IDLE)) || busy;

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: arithmetic reference model, directed corner cases and random ops.
module tb_muldiv_controller;
    import muldiv_controller_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    vec_t dir [13] = '{
        '{MD_MUL,    32'd7,          32'hFFFF_FFFD},
        '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF},
        '{MD_MULHSU, 32'hFFFF_FFFF,  32'd2},
        '{MD_DIV,    32'hFFFF_FFF9,  32'd2},
        '{MD_REM,    32'hFFFF_FFF9,  32'd2},
        '{MD_DIVU,   32'd100,        32'd7},
        '{MD_REMU,   32'd100,        32'd7},
        '{MD_DIV,    32'd5,          32'd0},
        '{MD_REM,    32'd5,          32'd0},
        '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF},
        '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF},
        '{MD_MUL,    32'd6,          32'd7},
        '{MD_MULH,   32'h8000_0000,  32'h8000_0000}
    };

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_controller_if #(.XLEN(XLEN)) bus ();

    muldiv_controller #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            MD_MUL:    begin p = sa * sb; return p[31:0];  end
            MD_MULH:   begin p = sa * sb; return p[63:32]; end
            MD_MULHSU: begin p = sa * ub; return p[63:32]; end
            MD_MULHU:  begin p = ua * ub; return p[63:32]; end
            MD_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            MD_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            MD_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) begin
            if (b == 32'd0) return 1;
            if ((f == MD_DIV || f == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return XLEN + 2;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return XLEN + 2;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.instType = INST_R_TYPE;
        bus.func7    = FUNC7_MULDIV;
        bus.func3    = f;
        bus.src1     = a;
        bus.src2     = b;
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit intrude);
        exp_t ex;
        int   errs;
        errs = 0;
        drive_md(f, a, b);
        bus.start = 1'b1;
        ex.res = ref_model(f, a, b);
        ex.lat = ref_lat(f, a, b);
        ex.acc = cyc;
        sbq.push_back(ex);
        #1;
        if (bus.stall !== 1'b1 || bus.isMulDiv !== 1'b1) errs++;
        for (int i = 1; i <= ex.lat + 1; i++) begin
            @(negedge clk);
            if (bus.stall !== (i < ex.lat)) errs++;
            if (bus.busy !== (i < ex.lat)) errs++;
            if (intrude && i == 3) begin
                bus.func3 = MD_DIVU;
                bus.src2  = 32'd0;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("stall_busy_seq", errs, 0);
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done with result %h, expected no done (cycle %0d)", bus.result, cyc);
                end else begin
                    ex = sbq.pop_front();
                    chk("result", bus.result, ex.res);
                    chk("latency", cyc - ex.acc, ex.lat);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] prior;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.instType = 4'd0;
        bus.func3    = 3'd0;
        bus.func7    = 7'd0;
        bus.src1     = '0;
        bus.src2     = '0;
        rst          = 1'b1;
        #12;
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_isMulDiv", bus.isMulDiv, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_op(dir[i].f, dir[i].a, dir[i].b, i == 0);
        end

        // Non-M R-type and M-encoding on a non-R class must leave the engine alone.
        bus.instType = INST_R_TYPE;
        bus.func7    = 7'd0;
        bus.func3    = 3'd0;
        bus.start    = 1'b1;
        #1;
        chk("add_isMulDiv", bus.isMulDiv, 0);
        chk("add_stall", bus.stall, 0);
        @(negedge clk);
        chk("add_busy", bus.busy, 0);
        bus.instType = INST_R_TYPE + 4'd1;
        bus.func7    = FUNC7_MULDIV;
        #1;
        chk("nonr_isMulDiv", bus.isMulDiv, 0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("nonr_done", bus.done, 0);

        // start+flush together in IDLE: flush wins, so no special-case done follows.
        drive_md(MD_DIV, 32'd5, 32'd0);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_idle_done", bus.done, 0);
        chk("flush_idle_busy", bus.busy, 0);
        @(negedge clk);

        // Flush in CALC cycle 10, then a new op in the very next cycle.
        run_op(MD_REMU, 32'd100, 32'd7, 1'b0);
        prior = ref_model(MD_REMU, 32'd100, 32'd7);
        drive_md(MD_DIVU, 32'd1000, 32'd3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", bus.busy, 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_done", bus.done, 0);
        chk("flush_result", bus.result, prior);
        run_op(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

        // Reset in the middle of CALC clears everything immediately.
        drive_md(MD_DIVU, 32'd1000, 32'd3);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_stall", bus.stall, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] f;
            f = 3'($urandom_range(0, 7));
            run_op(f, pick(), pick(), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
